somador_completo: RTL and testbench
===================================

# somador_completo

Parameterizable registered full adder. Computes `a + b + cin` over a WIDTH-bit ripple-carry chain built from 1-bit full-adder cells, then captures sum and carry-out in an output register with a valid flag. With WIDTH=1 it is the classic single-bit full adder. It is the arithmetic primitive used by datapath blocks that need a clocked add with explicit carry-in/carry-out.

## Interface
Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1–64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands valid; sampled on the rising edge of clk.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in into bit 0.
- s  output  WIDTH  registered sum, `(a + b + cin) mod 2^WIDTH`.
- cout  output  1  registered carry-out of the MSB cell.
- out_valid  output  1  high for exactly the cycle after an accepted in_valid.
- ovf  output  1  registered signed overflow; present only when SOMADOR_OVF_EN is defined.

## Operation
- **Bit-cell logic.** Each bit i uses a full-adder cell:
  - `s_i = a_i ^ b_i ^ c_i`
  - `c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i))`
  - `c_0 = cin`, and `cout = c_WIDTH`.
- **Structure.** The chain is built with a generate loop of cell instances. Do not infer it from a `+` operator.
- **Width rule.** The result is WIDTH+1 bits wide, formed as `{cout, s}`. No saturation is applied.
- **Capture (in_valid = 1).** On the rising edge, the register captures `s` and `cout` (and `ovf` if enabled), and sets `out_valid` to 1.
- **Hold (in_valid = 0).** On the rising edge, `s`, `cout` and `ovf` hold their previous values, and `out_valid` goes to 0.
- **Back-to-back operation.** There is no backpressure. A new operation is accepted every cycle, and `out_valid` stays high continuously when `in_valid` does.
- **Inputs while in_valid is low.** Operand inputs are don't-care and must not affect the outputs.
- **State.** There is no state machine. The only state is the output register.

## Timing
- **Reset values.** While rst_n = 0, all outputs are 0: `s`, `cout`, `out_valid` and `ovf`. This takes effect immediately, with no clock required.
- **Reset priority.** Reset asserted in the same cycle as in_valid wins; the operation is dropped.
- **Reset mid-stream.** Reset asserted mid-stream clears any pending result. After rst_n deasserts, the first edge with in_valid = 1 produces a result on the following cycle.
- **Latency.** 1 cycle: operands sampled at edge N appear on `s`/`cout`, with `out_valid` = 1, after edge N.
- **Throughput.** One operation per clock.
- **Combinational path.** The critical path is the WIDTH-cell carry chain from input to register. No timing requirement applies beyond a single-cycle path at the target clock.

## Configuration
- **Macro:** SOMADOR_OVF_EN.
- **Defined:**
  - The `ovf` port exists.
  - `ovf` is registered as `c_WIDTH ^ c_{WIDTH-1}`, i.e. two's-complement overflow of the signed interpretation.
  - `ovf` follows the same capture, hold and reset rules as `s`.
  - For WIDTH = 1, `c_{WIDTH-1}` is `cin`.
- **Not defined:**
  - The `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- **WIDTH=1, exhaustive truth table.** Apply (a,b,cin) = 000 through 111 with in_valid=1, one per cycle. Each result appears the next cycle:
  - {cout,s} = 00, 01, 01, 10, 01, 10, 10, 11.
  - out_valid stays high throughout.
- **WIDTH=8, carry propagation.**
  - a=8'hFF, b=8'h00, cin=1 → s=8'h00, cout=1.
  - a=8'h7F, b=8'h01, cin=0 → s=8'h80, cout=0, ovf=1 (with SOMADOR_OVF_EN).
- **Hold.** Load a=8'h12, b=8'h34, cin=0 → s=8'h46. Then drop in_valid and toggle a, b and cin randomly for 5 cycles → s stays 8'h46, cout stays 0, out_valid stays 0.
- **Asynchronous reset.** Load a=8'hF0, b=8'h20 → s=8'h10, cout=1. Pull rst_n low between clock edges → all outputs read 0 before the next edge. Release rst_n → outputs stay 0 until the next accepted operation.
- **Reset versus valid.** Hold rst_n=0 while in_valid=1 across an edge → no output change and out_valid=0. One cycle after release with in_valid=1 → the correct sum is presented.
- **Randomized cross-check.** 1000 random (a, b, cin) with random in_valid, WIDTH=16 → `{cout,s}` equals the reference `a+b+cin` one cycle after each accepted input.

Source files
------------

// File: rtl/somador_completo_if.sv
// Operand/result bundle for somador_completo; the ovf wire exists only when
// SOMADOR_OVF_EN is defined.
interface somador_completo_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             out_valid;
`ifdef SOMADOR_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin,
`ifdef SOMADOR_OVF_EN
    input  ovf,
`endif
    input  s, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SOMADOR_OVF_EN
    output ovf,
`endif
    output s, cout, out_valid
  );
endinterface

// File: rtl/somador_completo.sv
// Registered WIDTH-bit ripple-carry full adder built from 1-bit cells.
// Optional signed-overflow output enabled by defining SOMADOR_OVF_EN.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ c;
  assign co = (a & b) | (c & p);
endmodule

module somador_completo #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  somador_completo_if.slave bus
);
  // c[0] is the carry-in, c[WIDTH] the carry-out of the MSB cell
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .c  (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s         <= '0;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
`ifdef SOMADOR_OVF_EN
      bus.ovf       <= 1'b0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s    <= sum;
        bus.cout <= c[WIDTH];
`ifdef SOMADOR_OVF_EN
        bus.ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_somador_completo.sv
// Scoreboard bench for somador_completo at WIDTH 1, 8 and 16.
module tb_somador_completo;
  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];

  somador_completo_if #(.WIDTH(1))  bus1 ();
  somador_completo_if #(.WIDTH(8))  bus8 ();
  somador_completo_if #(.WIDTH(16)) bus16 ();

  somador_completo #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  somador_completo #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  somador_completo #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic cout, input logic ovf);
    exp_t e;
    e.s = s; e.cout = cout; e.ovf = ovf;
    return e;
  endfunction

  // Reference for the random run: wide integer add, overflow from operand/result signs
  function automatic exp_t ref16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    return mk(full[15:0], full[16],
              (a[15] & b[15] & ~full[15]) | (~a[15] & ~b[15] & full[15]));
  endfunction

  // Drive one cycle of stimulus at #1 after the rising edge
  task automatic drive(input int w, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    @(posedge clk);
    #1;
    bus1.in_valid  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
    case (w)
      1: begin bus1.in_valid = v;  bus1.a = a[0];    bus1.b = b[0];    bus1.cin = cin;  end
      8: begin bus8.in_valid = v;  bus8.a = a[7:0];  bus8.b = b[7:0];  bus8.cin = cin;  end
      default: begin bus16.in_valid = v; bus16.a = a; bus16.b = b; bus16.cin = cin; end
    endcase
  endtask

  task automatic idle();
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic chk8_zero(input string name);
    chk({name, " s"},         {24'b0, bus8.s},       32'h0);
    chk({name, " cout"},      {31'b0, bus8.cout},    32'h0);
    chk({name, " out_valid"}, {31'b0, bus8.out_valid}, 32'h0);
`ifdef SOMADOR_OVF_EN
    chk({name, " ovf"},       {31'b0, bus8.ovf},     32'h0);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus1.out_valid) begin
      if (q1.size() == 0) chk("w1 unexpected out_valid", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        chk("w1 s", {31'b0, bus1.s}, {16'b0, e.s});
        chk("w1 cout", {31'b0, bus1.cout}, {31'b0, e.cout});
`ifdef SOMADOR_OVF_EN
        chk("w1 ovf", {31'b0, bus1.ovf}, {31'b0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus8.out_valid) begin
      if (q8.size() == 0) chk("w8 unexpected out_valid", 32'h1, 32'h0);
      else begin
        e = q8.pop_front();
        chk("w8 s", {24'b0, bus8.s}, {16'b0, e.s});
        chk("w8 cout", {31'b0, bus8.cout}, {31'b0, e.cout});
`ifdef SOMADOR_OVF_EN
        chk("w8 ovf", {31'b0, bus8.ovf}, {31'b0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus16.out_valid) begin
      if (q16.size() == 0) chk("w16 unexpected out_valid", 32'h1, 32'h0);
      else begin
        e = q16.pop_front();
        chk("w16 s", {16'b0, bus16.s}, {16'b0, e.s});
        chk("w16 cout", {31'b0, bus16.cout}, {31'b0, e.cout});
`ifdef SOMADOR_OVF_EN
        chk("w16 ovf", {31'b0, bus16.ovf}, {31'b0, e.ovf});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // {ovf, cout, s} for (a,b,cin) = 000 .. 111
  logic [2:0] w1_tab [8] = '{3'b000, 3'b101, 3'b001, 3'b010,
                             3'b001, 3'b010, 3'b110, 3'b011};

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rv;
    logic [2:0]  idx;

    bus1.in_valid = 1'b0;  bus1.a = '0;  bus1.b = '0;  bus1.cin = 1'b0;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;

    #1;
    chk8_zero("reset w8");
    chk("reset w1 out_valid", {31'b0, bus1.out_valid}, 32'h0);
    chk("reset w16 out_valid", {31'b0, bus16.out_valid}, 32'h0);
    #22 rst_n = 1'b1;

    // WIDTH=1 truth table, back to back
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      drive(1, 1'b1, {15'b0, idx[2]}, {15'b0, idx[1]}, idx[0]);
      q1.push_back(mk({15'b0, w1_tab[i][0]}, w1_tab[i][1], w1_tab[i][2]));
      if (i > 0) chk("w1 out_valid continuous", {31'b0, bus1.out_valid}, 32'h1);
    end
    idle();
    chk("w1 out_valid last", {31'b0, bus1.out_valid}, 32'h1);
    idle();
    chk("w1 out_valid drop", {31'b0, bus1.out_valid}, 32'h0);

    // WIDTH=8 carry propagation
    drive(8, 1'b1, 16'h00FF, 16'h0000, 1'b1);
    q8.push_back(mk(16'h0000, 1'b1, 1'b0));
    drive(8, 1'b1, 16'h007F, 16'h0001, 1'b0);
    q8.push_back(mk(16'h0080, 1'b0, 1'b1));

    // Hold: operands toggle with in_valid low
    drive(8, 1'b1, 16'h0012, 16'h0034, 1'b0);
    q8.push_back(mk(16'h0046, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      drive(8, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      if (i > 0) begin
        chk("hold s", {24'b0, bus8.s}, 32'h46);
        chk("hold cout", {31'b0, bus8.cout}, 32'h0);
        chk("hold out_valid", {31'b0, bus8.out_valid}, 32'h0);
      end
    end

    // Asynchronous reset between edges
    drive(8, 1'b1, 16'h00F0, 16'h0020, 1'b0);
    q8.push_back(mk(16'h0010, 1'b1, 1'b0));
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk8_zero("async reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle();
    idle();
    chk8_zero("after release");

    // Mid-stream reset drops a pending operation
    drive(8, 1'b1, 16'h0001, 16'h0001, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 chk8_zero("mid-stream reset");
    #2 rst_n = 1'b1;
    idle();

    // Reset wins over in_valid, then first accepted op after release
    rst_n = 1'b0;
    drive(8, 1'b1, 16'h0055, 16'h00AA, 1'b1);
    @(posedge clk);
    #1 chk8_zero("reset vs valid");
    #2 rst_n = 1'b1;
    q8.push_back(mk(16'h0000, 1'b1, 1'b0));
    idle();
    idle();

    // WIDTH=16 random cross-check
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rv = 1'($urandom);
      if (i % 97 == 0) begin ra = 16'hFFFF; rb = 16'h0000; rc = 1'b1; rv = 1'b1; end
      drive(16, rv, ra, rb, rc);
      if (rv) q16.push_back(ref16(ra, rb, rc));
    end
    idle();
    idle();
    idle();

    chk("w1 queue drained", q1.size(), 32'h0);
    chk("w8 queue drained", q8.size(), 32'h0);
    chk("w16 queue drained", q16.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
